// File: rtl/axis_rr_sched_pkg.sv
// Shared types and default sizing for the round-robin stream scheduler.
package axis_rr_sched_pkg;

    localparam int unsigned CH_NUM_DEF    = 4;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned ORD_DEPTH_DEF = 8;
    localparam int unsigned CH_ID_W       = $clog2(CH_NUM_DEF);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } sched_state_t;

    // Channel index following id, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/axis_rr_sched_if.sv
// Bundle of N parallel AXI-stream lanes; lane i occupies bit i / slice i.
interface axis_rr_sched_if
    import axis_rr_sched_pkg::*;
#(
    parameter int unsigned N      = 1,
    parameter int unsigned DATA_W = DATA_W_DEF
);
    localparam int unsigned KEEP_W = DATA_W / 8;

    logic [N-1:0]        tvalid;
    logic [N-1:0]        tready;
    logic [N*DATA_W-1:0] tdata;
    logic [N*KEEP_W-1:0] tkeep;
    logic [N-1:0]        tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tkeep, input tlast, output tready);

endinterface

// File: rtl/axis_rr_sched_sync_fifo_id.sv
// Small in-order FIFO of channel IDs for packets in flight inside the core.
module sync_fifo_id #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 2,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_q];
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/axis_rr_sched.sv
// Packet round-robin sharing of one stream core between CH_NUM channels,
// with results routed back in request order via a channel-ID FIFO.
module axis_rr_sched
    import axis_rr_sched_pkg::*;
#(
    parameter int unsigned CH_NUM    = CH_NUM_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ORD_DEPTH = ORD_DEPTH_DEF,
    localparam int unsigned ID_W     = $clog2(CH_NUM),
    localparam int unsigned KEEP_W   = DATA_W / 8
) (
    input  logic              sys_clk,
    input  logic              perif_rst,
    input  logic              en,
    axis_rr_sched_if.slave    s,
    axis_rr_sched_if.master   m_core,
    axis_rr_sched_if.slave    s_core,
    axis_rr_sched_if.master   m,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy
);

    sched_state_t    state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] rr_q, rr_d;
    logic [ID_W-1:0] pick_id;
    logic            pick_vld;
    logic [ID_W-1:0] head_id;
    logic            push, pop, full, empty;
    int unsigned     idx;

    assign grant_id = grant_q;
    assign busy     = (state_q == XFER) || !empty;

    // First requesting channel at or after the round-robin pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        for (int unsigned k = 0; k < CH_NUM; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= CH_NUM) idx = idx - CH_NUM;
            if (!pick_vld && s.tvalid[ID_W'(idx)]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'(idx);
            end
        end
    end

    // Ingress FSM: grant in IDLE, pass the granted stream straight through in XFER.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        rr_d           = rr_q;
        push           = 1'b0;
        s.tready       = '0;
        m_core.tvalid  = 1'b0;
        m_core.tdata   = s.tdata[32'(grant_q)*DATA_W +: DATA_W];
        m_core.tkeep   = s.tkeep[32'(grant_q)*KEEP_W +: KEEP_W];
        m_core.tlast   = s.tlast[grant_q];
        case (state_q)
            IDLE: begin
                if (en && pick_vld && !full) begin
                    push    = 1'b1;
                    grant_d = pick_id;
                    state_d = XFER;
                end
            end
            XFER: begin
                m_core.tvalid     = s.tvalid[grant_q];
                s.tready[grant_q] = m_core.tready[0];
                if (s.tvalid[grant_q] && m_core.tready[0] && s.tlast[grant_q]) begin
                    state_d = IDLE;
                    rr_d    = ID_W'(rr_next(32'(grant_q), CH_NUM));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ingress state, grant and round-robin pointer registers.
    always_ff @(posedge sys_clk) begin
        if (perif_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    sync_fifo_id #(
        .DEPTH (ORD_DEPTH),
        .W     (ID_W)
    ) u_order (
        .clk_i   (sys_clk),
        .rst_i   (perif_rst),
        .push_i  (push),
        .data_i  (grant_d),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (full),
        .empty_o (empty)
    );

    // Egress: route core results to the channel at the head of the order FIFO.
    always_comb begin
        m.tvalid          = '0;
        m.tdata           = {CH_NUM{s_core.tdata}};
        m.tkeep           = {CH_NUM{s_core.tkeep}};
        m.tlast           = {CH_NUM{s_core.tlast}};
        m.tvalid[head_id] = s_core.tvalid[0] && !empty;
        s_core.tready     = !empty && m.tready[head_id];
        pop               = s_core.tvalid[0] && !empty && m.tready[head_id] && s_core.tlast[0];
    end

endmodule

// File: tb/tb_axis_rr_sched.sv
// Directed bench for axis_rr_sched with a 2-cycle passthrough core model.
module tb_axis_rr_sched;

    localparam int unsigned CH = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned KW = 4;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [3:0]  k;
        logic        l;
        logic [31:0] d;
    } beat_t;

    typedef struct {
        int    t;
        beat_t b;
    } core_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b1;
    logic [3:0]    sink_rdy = 4'hF;
    logic          core_rdy = 1'b1;
    logic [IW-1:0] grant_id;
    logic          busy;

    beat_t srcq [4][$];
    beat_t rxq  [4][$];
    beat_t expq [4][$];
    core_t cq[$];
    int    glog[$];
    int    arr[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    pkt_id = 0;
    bit    first = 1'b1;

    axis_rr_sched_if #(.N(CH), .DATA_W(DW)) s_if ();
    axis_rr_sched_if #(.N(1),  .DATA_W(DW)) mc_if ();
    axis_rr_sched_if #(.N(1),  .DATA_W(DW)) sc_if ();
    axis_rr_sched_if #(.N(CH), .DATA_W(DW)) m_if ();

    assign m_if.tready  = sink_rdy;
    assign mc_if.tready = core_rdy;

    axis_rr_sched #(.CH_NUM(CH), .DATA_W(DW), .ORD_DEPTH(8)) dut (
        .sys_clk   (clk),
        .perif_rst (rst),
        .en        (en),
        .s         (s_if),
        .m_core    (mc_if),
        .s_core    (sc_if),
        .m         (m_if),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500us");
        $fatal(1, "watchdog");
    end

    // Source and core-output drivers, updated on the falling edge.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (srcq[i].size() > 0) begin
                s_if.tvalid[i]        = 1'b1;
                s_if.tdata[i*32 +: 32] = srcq[i][0].d;
                s_if.tkeep[i*4 +: 4]   = srcq[i][0].k;
                s_if.tlast[i]         = srcq[i][0].l;
            end else begin
                s_if.tvalid[i]        = 1'b0;
                s_if.tdata[i*32 +: 32] = 32'd0;
                s_if.tkeep[i*4 +: 4]   = 4'd0;
                s_if.tlast[i]         = 1'b0;
            end
        end
        if (cq.size() > 0 && cyc >= cq[0].t + 2) begin
            sc_if.tvalid = 1'b1;
            sc_if.tdata  = cq[0].b.d;
            sc_if.tkeep  = cq[0].b.k;
            sc_if.tlast  = cq[0].b.l;
        end else begin
            sc_if.tvalid = 1'b0;
            sc_if.tdata  = 32'd0;
            sc_if.tkeep  = 4'd0;
            sc_if.tlast  = 1'b0;
        end
    end

    // Handshake monitor on the rising edge.
    always @(posedge clk) begin
        beat_t bt;
        for (int i = 0; i < 4; i++)
            if (s_if.tvalid[i] && s_if.tready[i] && srcq[i].size() > 0) srcq[i].delete(0);
        if (mc_if.tvalid[0] && mc_if.tready[0]) begin
            if (first) glog.push_back(int'(grant_id));
            first = mc_if.tlast[0];
            bt = '{k: mc_if.tkeep, l: mc_if.tlast[0], d: mc_if.tdata};
            cq.push_back('{t: cyc, b: bt});
        end
        if (sc_if.tvalid[0] && sc_if.tready[0] && cq.size() > 0) cq.delete(0);
        for (int i = 0; i < 4; i++) begin
            if (m_if.tvalid[i] && m_if.tready[i]) begin
                bt = '{k: m_if.tkeep[i*4 +: 4], l: m_if.tlast[i], d: m_if.tdata[i*32 +: 32]};
                rxq[i].push_back(bt);
                if (bt.l) arr.push_back(i);
            end
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic send(input int ch, input int nb);
        beat_t bt;
        for (int b = 0; b < nb; b++) begin
            bt.d = {8'(ch), 8'(pkt_id), 16'(b)};
            bt.l = (b == nb - 1);
            bt.k = bt.l ? 4'h7 : 4'hF;
            srcq[ch].push_back(bt);
            expq[ch].push_back(bt);
        end
        pkt_id++;
    endtask

    task automatic clr_logs();
        for (int i = 0; i < 4; i++) begin
            rxq[i].delete();
            expq[i].delete();
        end
        glog.delete();
        arr.delete();
    endtask

    task automatic clear_all();
        clr_logs();
        for (int i = 0; i < 4; i++) srcq[i].delete();
        cq.delete();
        first = 1'b1;
    endtask

    function automatic bit quiet();
        quiet = !busy && cq.size() == 0;
        for (int i = 0; i < 4; i++)
            if (srcq[i].size() != 0) quiet = 1'b0;
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int c;
        bit done;
        c = 0;
        done = 1'b0;
        while (!done && c < budget) begin
            step(1);
            c++;
            done = quiet();
        end
        chk({tag, " idle"}, 64'(done), 64'd1);
    endtask

    task automatic chk_rx(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s rx%0d count", tag, i), 64'(rxq[i].size()), 64'(expq[i].size()));
            for (int j = 0; j < rxq[i].size() && j < expq[i].size(); j++)
                chk($sformatf("%s rx%0d beat%0d", tag, i, j), 64'(rxq[i][j]), 64'(expq[i][j]));
        end
    endtask

    task automatic chk_glog(input string tag, input int k, input int exp_id);
        if (k < glog.size()) chk($sformatf("%s grant%0d", tag, k), 64'(glog[k]), 64'(exp_id));
        else chk($sformatf("%s grant%0d missing", tag, k), 64'(glog.size()), 64'(k + 1));
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(1);
        clear_all();
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        step(2);
        chk("rst s_tready", 64'(s_if.tready), 64'd0);
        chk("rst m_core_tvalid", 64'(mc_if.tvalid), 64'd0);
        chk("rst s_core_tready", 64'(sc_if.tready), 64'd0);
        chk("rst m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst grant_id", 64'(grant_id), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Single 4-beat packet on ch1
        send(1, 4);
        wait_idle(100, "t1");
        chk("t1 ngrant", 64'(glog.size()), 64'd1);
        chk_glog("t1", 0, 1);
        chk_rx("t1");
        chk("t1 busy", 64'(busy), 64'd0);

        // All channels, two 2-beat packets each, from a fresh pointer
        apply_reset();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 4; c++) send(c, 2);
        wait_idle(300, "t2");
        chk("t2 ngrant", 64'(glog.size()), 64'd8);
        for (int k = 0; k < 8; k++) chk_glog("t2", k, k % 4);
        chk_rx("t2");

        // Results blocked: order FIFO fills after 8 grants
        clr_logs();
        sink_rdy = 4'h0;
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < 4; c++) send(c, 1);
        step(40);
        chk("t3 ngrant at full", 64'(glog.size()), 64'd8);
        chk("t3 busy", 64'(busy), 64'd1);
        chk("t3 m_core_tvalid", 64'(mc_if.tvalid), 64'd0);
        chk("t3 s_tready", 64'(s_if.tready), 64'd0);
        chk("t3 s_core_tready", 64'(sc_if.tready), 64'd0);
        sink_rdy = 4'hF;
        wait_idle(300, "t3");
        chk("t3 ngrant", 64'(glog.size()), 64'd12);
        chk_rx("t3");

        // Head ch2 blocked holds back a queued ch0 result
        clr_logs();
        sink_rdy = 4'b1011;
        send(2, 2);
        step(4);
        send(0, 1);
        step(20);
        chk("t4 ngrant", 64'(glog.size()), 64'd2);
        chk_glog("t4", 0, 2);
        chk_glog("t4", 1, 0);
        chk("t4 s_core_tready", 64'(sc_if.tready), 64'd0);
        chk("t4 s_core_tvalid", 64'(sc_if.tvalid), 64'd1);
        chk("t4 m_tvalid", 64'(m_if.tvalid), 64'h4);
        chk("t4 rx0 held", 64'(rxq[0].size()), 64'd0);
        chk("t4 rx2 held", 64'(rxq[2].size()), 64'd0);
        sink_rdy = 4'hF;
        wait_idle(200, "t4");
        chk("t4 npkt", 64'(arr.size()), 64'd2);
        if (arr.size() >= 2) begin
            chk("t4 first out", 64'(arr[0]), 64'd2);
            chk("t4 second out", 64'(arr[1]), 64'd0);
        end
        chk_rx("t4");

        // en dropped mid-packet: packet completes, no further grants
        clr_logs();
        send(1, 6);
        step(3);
        en = 1'b0;
        for (int c = 0; c < 4; c++) send(c, 1);
        step(30);
        chk("t5 ngrant en=0", 64'(glog.size()), 64'd1);
        chk_glog("t5", 0, 1);
        chk("t5 rx1 beats", 64'(rxq[1].size()), 64'd6);
        chk("t5 busy", 64'(busy), 64'd0);
        chk("t5 m_core_tvalid", 64'(mc_if.tvalid), 64'd0);
        chk("t5 s_tready", 64'(s_if.tready), 64'd0);
        en = 1'b1;
        wait_idle(200, "t5");
        chk("t5 ngrant", 64'(glog.size()), 64'd5);
        chk_glog("t5", 1, 2);
        chk_glog("t5", 2, 3);
        chk_glog("t5", 3, 0);
        chk_glog("t5", 4, 1);
        chk_rx("t5");

        // Reset pulse in the middle of a packet
        clr_logs();
        send(2, 6);
        step(3);
        rst = 1'b1;
        step(1);
        chk("t6 s_tready", 64'(s_if.tready), 64'd0);
        chk("t6 m_core_tvalid", 64'(mc_if.tvalid), 64'd0);
        chk("t6 s_core_tready", 64'(sc_if.tready), 64'd0);
        chk("t6 m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("t6 grant_id", 64'(grant_id), 64'd0);
        chk("t6 busy", 64'(busy), 64'd0);
        clear_all();
        for (int c = 0; c < 4; c++) send(c, 1);
        step(1);
        rst = 1'b0;
        wait_idle(200, "t6");
        chk("t6 ngrant", 64'(glog.size()), 64'd4);
        for (int k = 0; k < 4; k++) chk_glog("t6", k, k);
        chk_rx("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
